// File: rtl/lvds_align_pkg.sv
// Shared types and helpers for the LVDS receive word aligner.
// One FSM state set is used by every channel instance.
package lvds_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hB4;

  // Bits needed to hold the value max_val without wrapping.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lvds_align_ch.sv
// One channel of the word aligner: compares the deserialised word
// against the training pattern and pulses bitslip until it matches.
module lvds_align_ch
  import lvds_align_pkg::*;
#(
  parameter int DESER       = 8,
  parameter logic [DESER-1:0] TRAIN_PATTERN =
    DESER'(TRAIN_PATTERN_DEF),
  parameter int MATCH_COUNT = 4,
  parameter int MAX_SLIPS   = 8,
  parameter int SLIP_HIGH   = 2,
  parameter int SLIP_WAIT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             retrain,
  input  logic [DESER-1:0] word,
  output logic             bitslip,
  output logic             locked,
  output logic             fail
);

  localparam int MW = cnt_w(MATCH_COUNT);
  localparam int SW = cnt_w(MAX_SLIPS);
  localparam int TW = cnt_w(
    (SLIP_HIGH > SLIP_WAIT) ? SLIP_HIGH : SLIP_WAIT);

  localparam logic [MW-1:0] MC_LAST = MW'(MATCH_COUNT - 1);
  localparam logic [SW-1:0] SL_MAX  = SW'(MAX_SLIPS);
  localparam logic [TW-1:0] T_HIGH  = TW'(SLIP_HIGH);
  localparam logic [TW-1:0] T_WAIT  = TW'(SLIP_WAIT);

  state_t          r_state;
  logic [MW-1:0]   r_match;
  logic [SW-1:0]   r_slip;
  logic [TW-1:0]   r_tmr;
  logic            r_bitslip;
  logic            r_locked;
  logic            r_fail;
  logic            w_hit;

  assign w_hit = (word == TRAIN_PATTERN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_match   <= '0;
      r_slip    <= '0;
      r_tmr     <= '0;
      r_bitslip <= 1'b0;
      r_locked  <= 1'b0;
      r_fail    <= 1'b0;
    end else if (!pll_locked || retrain) begin
      r_state   <= ST_IDLE;
      r_match   <= '0;
      r_slip    <= '0;
      r_tmr     <= '0;
      r_bitslip <= 1'b0;
      r_locked  <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_state <= ST_CHECK;
          r_match <= '0;
          r_slip  <= '0;
        end
        ST_CHECK: begin
          if (w_hit) begin
            r_match <= r_match + 1'b1;
            if (r_match == MC_LAST) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end
          end else if (r_slip == SL_MAX) begin
            r_state <= ST_FAIL;
            r_fail  <= 1'b1;
          end else begin
            r_state   <= ST_SLIP;
            r_match   <= '0;
            r_slip    <= r_slip + 1'b1;
            r_tmr     <= TW'(1);
            r_bitslip <= 1'b1;
          end
        end
        ST_SLIP: begin
          // Timer counts cycles already spent in the state.
          if (r_tmr == T_HIGH) begin
            r_bitslip <= 1'b0;
            r_tmr     <= TW'(1);
            r_state   <= (SLIP_WAIT == 0) ? ST_CHECK : ST_WAIT;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_tmr == T_WAIT) begin
            r_state <= ST_CHECK;
            r_tmr   <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_LOCKED, ST_FAIL: r_state <= r_state;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bitslip = r_bitslip;
  assign locked  = r_locked;
  assign fail    = r_fail;

endmodule

// File: rtl/lvds_rx_word_align.sv
// Multi-channel LVDS receive word aligner with a registered
// data/valid output stage in the parallel clock domain.
module lvds_rx_word_align
  import lvds_align_pkg::*;
#(
  parameter int NUM_CH      = 1,
  parameter int DESER       = 8,
  parameter logic [DESER-1:0] TRAIN_PATTERN =
    DESER'(TRAIN_PATTERN_DEF),
  parameter int MATCH_COUNT = 4,
  parameter int MAX_SLIPS   = 8,
  parameter int SLIP_HIGH   = 2,
  parameter int SLIP_WAIT   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic                    retrain,
  input  logic [NUM_CH*DESER-1:0] rx_data,
  output logic [NUM_CH-1:0]       bitslip,
  output logic [NUM_CH-1:0]       ch_locked,
  output logic [NUM_CH-1:0]       align_fail,
  output logic                    all_locked,
  output logic [NUM_CH*DESER-1:0] data_out,
  output logic                    data_valid
);

  logic [NUM_CH*DESER-1:0] r_data;
  logic                    r_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    lvds_align_ch #(
      .DESER        (DESER),
      .TRAIN_PATTERN(TRAIN_PATTERN),
      .MATCH_COUNT  (MATCH_COUNT),
      .MAX_SLIPS    (MAX_SLIPS),
      .SLIP_HIGH    (SLIP_HIGH),
      .SLIP_WAIT    (SLIP_WAIT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pll_locked(pll_locked),
      .retrain   (retrain),
      .word      (rx_data[g*DESER +: DESER]),
      .bitslip   (bitslip[g]),
      .locked    (ch_locked[g]),
      .fail      (align_fail[g])
    );
  end

  assign all_locked = &ch_locked;

  // Data is forwarded regardless of lock; consumers gate on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= rx_data;
      r_valid <= all_locked;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;

endmodule

// File: tb/tb_lvds_rx_word_align.sv
// Bench for lvds_rx_word_align: rotating deserialiser stub,
// timeline model of the training sequence, directed scenarios.
module tb_lvds_rx_word_align;

  localparam int NC  = 4;
  localparam int DW  = 8;
  localparam int MC  = 4;
  localparam int MS  = 8;
  localparam int SH  = 2;
  localparam int SW  = 4;
  localparam int PER = 1 + SH + SW;
  localparam logic [7:0] PAT = 8'hB4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic retrain = 1'b0;
  logic [NC*DW-1:0] rx_data = '0;
  logic [NC-1:0]    bitslip;
  logic [NC-1:0]    ch_locked;
  logic [NC-1:0]    align_fail;
  logic             all_locked;
  logic [NC*DW-1:0] data_out;
  logic             data_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lvds_rx_word_align #(
    .NUM_CH       (NC),
    .DESER        (DW),
    .TRAIN_PATTERN(PAT),
    .MATCH_COUNT  (MC),
    .MAX_SLIPS    (MS),
    .SLIP_HIGH    (SH),
    .SLIP_WAIT    (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .retrain   (retrain),
    .rx_data   (rx_data),
    .bitslip   (bitslip),
    .ch_locked (ch_locked),
    .align_fail(align_fail),
    .all_locked(all_locked),
    .data_out  (data_out),
    .data_valid(data_valid)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Deserialiser stub: word rotates left once per bitslip rise,
  // SW cycles after the rise is seen.
  int          rot[NC];
  int          off[NC];
  int          pulses[NC];
  logic [SW-1:0] dly[NC];
  logic [NC-1:0] bs_prev;
  bit          constz;
  bit          payload;
  logic [7:0]  pay[NC];

  function automatic logic [7:0] rotl8(input logic [7:0] w,
                                       input int r);
    int q;
    logic [15:0] t;
    q = ((r % 8) + 8) % 8;
    t = {w, w} << q;
    return t[15:8];
  endfunction

  always @(posedge clk) begin
    logic ev;
    #2;
    for (int k = 0; k < NC; k++) begin
      ev = bitslip[k] & ~bs_prev[k];
      if (ev) pulses[k]++;
      if (dly[k][SW-1]) rot[k]++;
      dly[k] = {dly[k][SW-2:0], ev};
      if (constz)
        rx_data[k*DW +: DW] = '0;
      else if (payload)
        rx_data[k*DW +: DW] = pay[k];
      else
        rx_data[k*DW +: DW] = rotl8(PAT, rot[k] - off[k]);
    end
    bs_prev = bitslip;
  end

  // Timeline model: n = edges since the channel left IDLE,
  // s = slips needed to align (-1: never aligns).
  int n[NC] = '{default: -1};
  int s[NC] = '{default: 0};
  logic [NC*DW-1:0] exp_data = '0;
  logic             exp_dv = 1'b0;

  function automatic logic m_lk(input int nn, input int ss);
    return (ss >= 0) && (nn >= PER * ss + MC);
  endfunction

  function automatic logic m_fl(input int nn, input int ss);
    return (ss < 0) && (nn >= PER * MS + 1);
  endfunction

  function automatic logic m_bs(input int nn, input int ss);
    int lim;
    if (nn < 1) return 1'b0;
    lim = (ss < 0) ? MS : ss;
    return ((nn - 1) / PER < lim) && ((nn - 1) % PER < SH);
  endfunction

  always @(posedge clk) begin
    logic al;
    if (!rst_n) begin
      for (int k = 0; k < NC; k++) n[k] = -1;
      exp_data = '0;
      exp_dv = 1'b0;
    end else begin
      al = 1'b1;
      for (int k = 0; k < NC; k++) al &= m_lk(n[k], s[k]);
      exp_dv = al;
      exp_data = rx_data;
      for (int k = 0; k < NC; k++) begin
        if (!pll_locked || retrain) n[k] = -1;
        else if (n[k] < 0) n[k] = 0;
        else if (n[k] < 1000000) n[k]++;
      end
    end
  end

  always @(negedge clk) begin
    logic [NC-1:0] e_bs, e_lk, e_fl;
    for (int k = 0; k < NC; k++) begin
      e_bs[k] = m_bs(n[k], s[k]);
      e_lk[k] = m_lk(n[k], s[k]);
      e_fl[k] = m_fl(n[k], s[k]);
    end
    chk("bitslip", 64'(bitslip), 64'(e_bs));
    chk("ch_locked", 64'(ch_locked), 64'(e_lk));
    chk("align_fail", 64'(align_fail), 64'(e_fl));
    chk("all_locked", 64'(all_locked), 64'(&e_lk));
    chk("data_valid", 64'(data_valid), 64'(exp_dv));
    chk("data_out", 64'(data_out), 64'(exp_data));
  end

  task automatic cfg(input int o0, input int o1,
                     input int o2, input int o3, input bit cz);
    int o[NC];
    o = '{o0, o1, o2, o3};
    for (int k = 0; k < NC; k++) begin
      off[k] = o[k];
      s[k] = cz ? -1 : o[k];
      rot[k] = 0;
      dly[k] = '0;
      pulses[k] = 0;
      pay[k] = 8'h00;
    end
    bs_prev = '0;
    constz = cz;
    payload = 1'b0;
  endtask

  task automatic chk_pulses(input string nm, input int p0,
                            input int p1, input int p2, input int p3);
    int p[NC];
    p = '{p0, p1, p2, p3};
    for (int k = 0; k < NC; k++) chk(nm, 64'(pulses[k]), 64'(p[k]));
  endtask

  initial begin
    int cnt;
    cfg(0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_bitslip", 64'(bitslip), 64'h0);
    chk("rst_locked", 64'(ch_locked), 64'h0);
    chk("rst_dv", 64'(data_valid), 64'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("nopll_locked", 64'(ch_locked), 64'h0);

    // Aligned channels
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);
    chk("s1_prelock", 64'(ch_locked), 64'h0);
    @(negedge clk);
    chk("s1_lock", 64'(ch_locked), 64'hF);
    chk("s1_dv_lag", 64'(data_valid), 64'h0);
    @(negedge clk);
    chk("s1_dv", 64'(data_valid), 64'h1);
    chk("s1_data", 64'(data_out), 64'hB4B4B4B4);
    chk_pulses("s1_pulses", 0, 0, 0, 0);

    // Payload traffic must not disturb lock
    payload = 1'b1;
    repeat (6) begin
      for (int k = 0; k < NC; k++) pay[k] = 8'($urandom);
      @(negedge clk);
    end
    payload = 1'b0;
    repeat (3) @(negedge clk);
    chk("s1_payload_lock", 64'(ch_locked), 64'hF);

    // PLL loss while locked
    pll_locked = 1'b0;
    @(negedge clk);
    chk("pll_drop_lock", 64'(ch_locked), 64'h0);
    chk("pll_drop_all", 64'(all_locked), 64'h0);
    chk("pll_drop_dv1", 64'(data_valid), 64'h1);
    @(negedge clk);
    chk("pll_drop_dv0", 64'(data_valid), 64'h0);
    repeat (2) @(negedge clk);
    pll_locked = 1'b1;
    repeat (5) @(negedge clk);
    chk("reacq_lock", 64'(ch_locked), 64'hF);

    // Offset 3 on every channel
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    cfg(3, 3, 3, 3, 1'b0);
    pll_locked = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (all_locked !== 1'b1 && cnt < 300);
    chk("off3_lock_time", 64'(cnt), 64'd26);
    chk("off3_fail", 64'(align_fail), 64'h0);
    chk_pulses("off3_pulses", 3, 3, 3, 3);

    // Mixed offsets
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    cfg(0, 1, 5, 7, 1'b0);
    pll_locked = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (all_locked !== 1'b1 && cnt < 300);
    chk("mix_lock_time", 64'(cnt), 64'd54);
    chk_pulses("mix_pulses", 0, 1, 5, 7);
    @(negedge clk);
    chk("mix_dv", 64'(data_valid), 64'h1);

    // Constant data never aligns
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    cfg(0, 0, 0, 0, 1'b1);
    pll_locked = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (align_fail !== 4'hF && cnt < 300);
    chk("fail_time", 64'(cnt), 64'd58);
    chk("fail_locked", 64'(ch_locked), 64'h0);
    chk_pulses("fail_pulses", 8, 8, 8, 8);
    repeat (10) @(negedge clk);
    chk("fail_held", 64'(align_fail), 64'hF);

    // Retrain out of FAIL, then again mid-slip
    retrain = 1'b1;
    @(negedge clk);
    retrain = 1'b0;
    chk("rt_fail_clr", 64'(align_fail), 64'h0);
    repeat (2) @(negedge clk);
    chk("rt_slip_hi", 64'(bitslip), 64'hF);
    retrain = 1'b1;
    @(negedge clk);
    retrain = 1'b0;
    chk("rt_slip_cut", 64'(bitslip), 64'h0);
    for (int k = 0; k < NC; k++) pulses[k] = 0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (align_fail !== 4'hF && cnt < 300);
    chk("rt_fail_time", 64'(cnt), 64'd58);
    chk_pulses("rt_pulses", 8, 8, 8, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
